// File: rtl/dmem_fill_pkg.sv
// Shared data-cache refill configuration: line geometry, bus width and fill-engine state encoding.
package dmem_fill_pkg;

    localparam int unsigned DMEM_LINE    = 256;
    localparam int unsigned DMEM_BLK_LEN = 59;
    localparam int unsigned DMEM_BUS_W   = 64;
    localparam int unsigned DMEM_BEATS   = DMEM_LINE / DMEM_BUS_W;
    localparam int unsigned DMEM_OFFS    = 64 - DMEM_BLK_LEN;

    typedef enum logic [1:0] {
        DMEM_F_IDLE = 2'd0,
        DMEM_F_REQ  = 2'd1,
        DMEM_F_BEAT = 2'd2,
        DMEM_F_DONE = 2'd3
    } dmem_f_state_e;

endpackage

// File: rtl/dmem_fill.sv
// Data-cache line refill engine: one burst read per request, beats assembled
// little-endian into a full line, delivered with a single-cycle valid pulse.
module dmem_fill
    import dmem_fill_pkg::*;
#(
    parameter int unsigned LINE_W  = DMEM_LINE,
    parameter int unsigned BUS_W   = DMEM_BUS_W,
    parameter int unsigned BLK_LEN = DMEM_BLK_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BLK_LEN-1:0] b_addr_d,
    input  logic               b_rd_d,
    output logic [LINE_W-1:0]  b_rdata_d,
    output logic               b_dv_d,
    output logic [63:0]        m_addr,
    output logic               m_rd,
    input  logic               m_ack,
    input  logic [BUS_W-1:0]   m_rdata,
    input  logic               m_rvalid
);

    localparam int unsigned BEATS = LINE_W / BUS_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFFS  = 64 - BLK_LEN;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    dmem_f_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              abort_q, abort_d;
    logic              m_rd_q, m_rd_d;
    logic [63:0]       m_addr_q, m_addr_d;
    logic              dv_q, dv_d;
    logic [LINE_W-1:0] line_q, line_d;

    // Next-state, beat placement and registered-output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        m_rd_d   = 1'b0;
        m_addr_d = m_addr_q;
        dv_d     = 1'b0;
        line_d   = line_q;

        case (state_q)
            DMEM_F_IDLE: begin
                if (b_rd_d) begin
                    m_addr_d = {b_addr_d, {OFFS{1'b0}}};
                    m_rd_d   = 1'b1;
                    state_d  = DMEM_F_REQ;
                end
            end
            DMEM_F_REQ: begin
                abort_d = abort_q | ~b_rd_d;
                if (m_ack) begin
                    cnt_d   = '0;
                    state_d = DMEM_F_BEAT;
                end else begin
                    m_rd_d = 1'b1;
                end
            end
            DMEM_F_BEAT: begin
                abort_d = abort_q | ~b_rd_d;
                if (m_rvalid) begin
                    for (int unsigned i = 0; i < BEATS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            line_d[i*BUS_W +: BUS_W] = m_rdata;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    // Last beat: an abandoned fill drains silently, otherwise deliver the line
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d = '0;
                        if (abort_d) begin
                            abort_d = 1'b0;
                            state_d = DMEM_F_IDLE;
                        end else begin
                            dv_d    = 1'b1;
                            state_d = DMEM_F_DONE;
                        end
                    end
                end
            end
            DMEM_F_DONE: begin
                state_d = DMEM_F_IDLE;
            end
            default: begin
                state_d = DMEM_F_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= DMEM_F_IDLE;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            m_rd_q   <= 1'b0;
            m_addr_q <= '0;
            dv_q     <= 1'b0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            m_rd_q   <= m_rd_d;
            m_addr_q <= m_addr_d;
            dv_q     <= dv_d;
            line_q   <= line_d;
        end
    end

    assign b_rdata_d = line_q;
    assign b_dv_d    = dv_q;
    assign m_addr    = m_addr_q;
    assign m_rd      = m_rd_q;

endmodule

// File: tb/tb_dmem_fill.sv
// Directed bench for dmem_fill with a bus model and a queue of expected lines.
module tb_dmem_fill;

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned BUS_W   = 64;
    localparam int unsigned BLK_LEN = 59;
    localparam int unsigned BEATS   = LINE_W / BUS_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [BLK_LEN-1:0] b_addr_d;
    logic               b_rd_d;
    logic [LINE_W-1:0]  b_rdata_d;
    logic               b_dv_d;
    logic [63:0]        m_addr;
    logic               m_rd;
    logic               m_ack;
    logic [BUS_W-1:0]   m_rdata;
    logic               m_rvalid;

    always #5 clk = ~clk;

    dmem_fill dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .b_addr_d  (b_addr_d),
        .b_rd_d    (b_rd_d),
        .b_rdata_d (b_rdata_d),
        .b_dv_d    (b_dv_d),
        .m_addr    (m_addr),
        .m_rd      (m_rd),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata),
        .m_rvalid  (m_rvalid)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_dv     = 0;
    logic [LINE_W-1:0] exp_q[$];
    logic [LINE_W-1:0] last_line;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, and score any delivered line
    task automatic tick();
        logic [LINE_W-1:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (b_dv_d === 1'b1) begin
            n_dv++;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 'x;
            chk("line_data", b_rdata_d, e);
        end
    endtask

    task automatic run_fill(input logic [BLK_LEN-1:0] addr, input int ack_wait, input int gap_beat,
                            input logic [BUS_W-1:0] base, input int drop_beat, input bit spurious);
        int c0;
        bit aborted;
        logic [LINE_W-1:0] line;
        logic [63:0] exp_addr;
        aborted  = (drop_beat >= 0);
        exp_addr = {addr, 5'b0};
        for (int b = 0; b < int'(BEATS); b++) line[b*BUS_W +: BUS_W] = base + BUS_W'(b);
        if (!aborted) exp_q.push_back(line);

        b_addr_d = addr;
        b_rd_d   = 1'b1;
        c0       = cyc;
        tick();
        chk("m_rd_rise", LINE_W'(m_rd), LINE_W'(1'b1));
        chk("m_addr", LINE_W'(m_addr), LINE_W'(exp_addr));
        b_addr_d = ~addr;

        for (int i = 0; i < ack_wait; i++) begin
            if (spurious) begin
                m_rvalid = 1'b1;
                m_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
            end
            tick();
            m_rvalid = 1'b0;
            chk("m_rd_held", LINE_W'(m_rd), LINE_W'(1'b1));
            chk("m_addr_held", LINE_W'(m_addr), LINE_W'(exp_addr));
            if (spurious) chk("rdata_spurious_req", b_rdata_d, last_line);
        end

        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("m_rd_drop", LINE_W'(m_rd), LINE_W'(1'b0));

        for (int b = 0; b < int'(BEATS); b++) begin
            if (aborted && b == drop_beat + 1) b_rd_d = 1'b0;
            m_rvalid = 1'b1;
            m_rdata  = line[b*BUS_W +: BUS_W];
            tick();
            m_rvalid = 1'b0;
            m_rdata  = '1;
            if (b < int'(BEATS) - 1) chk("no_early_dv", LINE_W'(b_dv_d), LINE_W'(1'b0));
            if (b == gap_beat) begin
                tick();
                chk("gap_no_dv", LINE_W'(b_dv_d), LINE_W'(1'b0));
            end
        end

        chk("dv_pulse", LINE_W'(b_dv_d), LINE_W'(!aborted));
        if (!aborted)
            chk("dv_cycle", LINE_W'(cyc - c0), LINE_W'(2 + ack_wait + int'(BEATS) + (gap_beat >= 0 ? 1 : 0)));
        last_line = line;
        b_rd_d    = 1'b0;
        tick();
        chk("dv_single", LINE_W'(b_dv_d), LINE_W'(1'b0));
        chk("idle_no_m_rd", LINE_W'(m_rd), LINE_W'(1'b0));
        chk("rdata_hold", b_rdata_d, last_line);
    endtask

    initial begin
        rst_n     = 1'b0;
        b_addr_d  = '0;
        b_rd_d    = 1'b0;
        m_ack     = 1'b0;
        m_rdata   = '0;
        m_rvalid  = 1'b0;
        last_line = '0;

        tick();
        tick();
        chk("rst_m_rd", LINE_W'(m_rd), LINE_W'(1'b0));
        chk("rst_m_addr", LINE_W'(m_addr), LINE_W'(64'h0));
        chk("rst_dv", LINE_W'(b_dv_d), LINE_W'(1'b0));
        chk("rst_rdata", b_rdata_d, '0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", LINE_W'(m_rd), LINE_W'(1'b0));

        // Basic fill, then bus wait with a gap after beat 1
        run_fill(59'h1, 0, -1, 64'hA0, -1, 1'b0);
        run_fill(59'h2, 3, 1, 64'hB0, -1, 1'b0);

        // Abort after beat 1, then a follow-up request
        run_fill(59'h3, 0, -1, 64'hC0, 1, 1'b0);
        run_fill(59'h5, 0, -1, 64'hD0, -1, 1'b0);

        // Back-to-back fills
        run_fill(59'h7, 0, -1, 64'hE0, -1, 1'b0);
        run_fill(59'h8, 1, -1, 64'h1234_5678_9ABC_0000, -1, 1'b0);

        // Spurious beats in IDLE, then in REQ
        m_rvalid = 1'b1;
        m_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        tick();
        m_rvalid = 1'b0;
        chk("rdata_spurious_idle", b_rdata_d, last_line);
        chk("dv_spurious_idle", LINE_W'(b_dv_d), LINE_W'(1'b0));
        chk("m_rd_spurious_idle", LINE_W'(m_rd), LINE_W'(1'b0));
        run_fill(59'h9, 2, -1, 64'hF0, -1, 1'b1);

        // Reset during beat 2
        b_addr_d = 59'h4;
        b_rd_d   = 1'b1;
        tick();
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = 64'h5500 + BUS_W'(b);
            tick();
        end
        m_rdata = 64'h5502;
        rst_n   = 1'b0;
        tick();
        m_rvalid = 1'b0;
        b_rd_d   = 1'b0;
        chk("midrst_m_rd", LINE_W'(m_rd), LINE_W'(1'b0));
        chk("midrst_m_addr", LINE_W'(m_addr), LINE_W'(64'h0));
        chk("midrst_dv", LINE_W'(b_dv_d), LINE_W'(1'b0));
        chk("midrst_rdata", b_rdata_d, '0);
        rst_n     = 1'b1;
        last_line = '0;
        tick();
        chk("midrst_idle", LINE_W'(m_rd), LINE_W'(1'b0));
        run_fill(59'hA, 1, 2, 64'h7700, -1, 1'b1);

        chk("dv_total", LINE_W'(n_dv), LINE_W'(7));
        chk("queue_drained", LINE_W'(exp_q.size()), LINE_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
